seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked ALU replacing the purely combinational datapath ALU for the multi-cycle core. It executes logic, add/sub and compare operations in one registered cycle. It executes unsigned multiply and divide iteratively over WIDTH cycles. Operands and results move through valid/ready handshakes, so the controller can stall on long operations.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥ 4)
- OP_W, 4, width of op code

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- in_valid  input  1  operands/op presented
- in_ready  output  1  block accepts a new operation
- op  input  OP_W  operation code
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result registered and held
- out_ready  input  1  consumer takes result
- y  output  WIDTH  primary result
- y_hi  output  WIDTH  MUL high half / DIVU remainder; 0 for other ops
- zero  output  1  y == 0
- ovf  output  1  signed overflow on ADD/SUB; 0 otherwise
- err  output  1  illegal op or divide-by-zero

## Operation
Op codes:
- 0 AND
- 1 OR
- 2 ADD
- 3 SUB
- 4 SLT (signed)
- 5 SLTU
- 6 MUL (unsigned, 2·WIDTH product: {y_hi, y})
- 7 DIVU (y = quotient, y_hi = remainder)
- 8 OFF: y = 0, zero = 1
- All other codes are illegal: y = 0, y_hi = 0, err = 1.

Rules:
- Results are WIDTH-bit modulo.
- SLT/SLTU produce y = 1 or 0.
- ovf = (a[MSB]==b'[MSB]) && (y[MSB]!=a[MSB]), where b' = b for ADD and ~b+1 for SUB.
- DIVU with b = 0: y = all ones, y_hi = a, err = 1. The iteration is skipped.
- zero is always computed from the registered y.

FSM:
- IDLE: in_ready = 1.
  - Handshake with a single-cycle op → DONE, with the result registered.
  - Handshake with MUL/DIVU → CALC, with the operands latched.
- CALC: shift-add (MUL) or restoring division (DIVU), one bit per cycle. A counter runs WIDTH-1 down to 0. The counter reaching 0 → DONE.
- DONE: out_valid = 1, and outputs stay stable until out_ready. out_valid && out_ready → IDLE.
- in_ready = 0 in CALC and DONE. There is no overlap: a new op is accepted only in IDLE, so at most one op is in flight.

Reset (rst_n low at a clock edge):
- state = IDLE.
- y, y_hi, zero, ovf, err, out_valid = 0; in_ready = 1 after reset.
- A reset during CALC or DONE aborts the operation; no result is emitted.

## Timing
- Single-cycle op accepted at edge N → out_valid high after edge N+1.
- MUL/DIVU accepted at edge N → out_valid high after edge N+WIDTH+1.
- DIVU by zero: same latency as single-cycle ops.
- out_ready held high at the result edge: out_valid lasts exactly one cycle. in_ready rises the following cycle.
- in_valid while in_ready = 0 is ignored. The sender must hold in_valid and operands until in_ready.
- Outputs are registered only; there is no combinational path from inputs to y.

## Configuration
- SEQ_ALU_MULDIV_EN defined: ops 6 and 7 are implemented as above, and the CALC state and iterative core are present.
- SEQ_ALU_MULDIV_EN undefined:
  - Ops 6 and 7 are treated as illegal: single-cycle, err = 1, y = y_hi = 0.
  - CALC and the iterative core are not synthesised.

## Structure
- Shared constants header holds:
  - op code defines (ALU_AND … ALU_OFF), also used by the controller
  - FSM state encodings
  - the WIDTH-bit zero constant
- Sub-module iter_muldiv: takes start, a, b, is_div and produces done, lo, hi.
  - It owns the bit counter and the shift registers.
  - It is instantiated only under SEQ_ALU_MULDIV_EN.
- Top level holds the FSM, the single-cycle datapath, flag logic and output registers.

## Test plan
All scenarios use WIDTH = 32.
- ADD a = 0x7FFFFFFF, b = 1 → y = 0x80000000, ovf = 1, zero = 0, out_valid after 1 cycle.
- SUB a = 8, b = 8 → y = 0, zero = 1. SLT a = 0xFFFFFFFD, b = 0xFFFFFFFB → y = 0. SLTU a = 1, b = 0xFFFFFFFF → y = 1.
- MUL a = 0xFFFFFFFF, b = 2 → y = 0xFFFFFFFE, y_hi = 1, out_valid after exactly 33 cycles.
- DIVU a = 41, b = 8 → y = 5, y_hi = 1. DIVU b = 0 → y = 0xFFFFFFFF, y_hi = a, err = 1.
- Hold out_ready = 0 for 5 cycles in DONE → outputs stable, in_ready = 0, a new in_valid is ignored.
- Assert rst_n low mid-CALC → next cycle out_valid = 0, in_ready = 1, all outputs 0. Op 0xF → err = 1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared constants for seq_alu and the core controller: op codes and FSM
// state encodings. Optional feature macro: SEQ_ALU_MULDIV_EN.
package seq_alu_pkg;

  localparam int unsigned ALU_AND  = 0;
  localparam int unsigned ALU_OR   = 1;
  localparam int unsigned ALU_ADD  = 2;
  localparam int unsigned ALU_SUB  = 3;
  localparam int unsigned ALU_SLT  = 4;
  localparam int unsigned ALU_SLTU = 5;
  localparam int unsigned ALU_MUL  = 6;
  localparam int unsigned ALU_DIVU = 7;
  localparam int unsigned ALU_OFF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per
// cycle. The first step is taken on the start edge directly from the
// operands, so done rises WIDTH cycles after start. Only built when
// SEQ_ALU_MULDIV_EN is defined.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_div,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_div;
  logic [WIDTH-1:0] r_lo, r_hi, r_b;

  logic [WIDTH-1:0] w_lo, w_hi, w_b, w_lo_nxt, w_hi_nxt;
  logic             w_div;
  logic [WIDTH:0]   w_sum, w_rem, w_diff;

  // One iteration step, sourced from the operands on the start cycle
  always_comb begin
    w_lo   = start ? a : r_lo;
    w_hi   = start ? '0 : r_hi;
    w_b    = start ? b : r_b;
    w_div  = start ? is_div : r_div;
    w_sum  = {1'b0, w_hi} + {1'b0, w_b};
    w_rem  = {w_hi, w_lo[WIDTH-1]};
    w_diff = w_rem - {1'b0, w_b};
    if (w_div) begin
      if (!w_diff[WIDTH]) begin
        w_hi_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {w_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_rem[WIDTH-1:0];
        w_lo_nxt = {w_lo[WIDTH-2:0], 1'b0};
      end
    end else if (w_lo[0]) begin
      {w_hi_nxt, w_lo_nxt} = {w_sum, w_lo[WIDTH-1:1]};
    end else begin
      {w_hi_nxt, w_lo_nxt} = {1'b0, w_hi, w_lo[WIDTH-1:1]};
    end
  end

  // Bit counter: WIDTH-1 after start, counts down; zero marks completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(WIDTH - 1);
    end else if (r_busy) begin
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end

  // Shift registers: data only, no reset needed
  always_ff @(posedge clk) begin
    if (start || (r_busy && r_cnt != '0)) begin
      r_lo <= w_lo_nxt;
      r_hi <= w_hi_nxt;
    end
    if (start) begin
      r_b   <= b;
      r_div <= is_div;
    end
  end

  assign done = r_busy && (r_cnt == '0);
  assign lo   = r_lo;
  assign hi   = r_hi;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/compare ops, optional iterative
// MUL/DIVU (enabled by SEQ_ALU_MULDIV_EN). At most one op in flight.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             zero,
  output logic             ovf,
  output logic             err
);
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_y, r_y_hi;
  logic             r_zero, r_ovf, r_err;

  logic [WIDTH-1:0] w_y, w_y_hi, w_sum, w_dif;
  logic signed [WIDTH-1:0] w_a_s, w_b_s;
  logic             w_ovf, w_err, w_is_long, w_acc;

  // Signed overflow: operands agree in sign but the result does not
  function automatic logic f_ovf(input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] bp,
                                 input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] == bp[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign w_acc = in_valid && (r_state == ST_IDLE);
  assign w_sum = a + b;
  assign w_dif = a - b;
  assign w_a_s = a;
  assign w_b_s = b;

  // Single-cycle datapath and classification of long ops
  always_comb begin
    w_y       = ZERO_W;
    w_y_hi    = ZERO_W;
    w_ovf     = 1'b0;
    w_err     = 1'b0;
    w_is_long = 1'b0;
    case (op)
      OP_W'(ALU_AND):  w_y = a & b;
      OP_W'(ALU_OR):   w_y = a | b;
      OP_W'(ALU_ADD): begin
        w_y   = w_sum;
        w_ovf = f_ovf(a, b, w_sum);
      end
      OP_W'(ALU_SUB): begin
        w_y   = w_dif;
        w_ovf = f_ovf(a, ~b + 1'b1, w_dif);
      end
      OP_W'(ALU_SLT):  w_y = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      OP_W'(ALU_SLTU): w_y = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef SEQ_ALU_MULDIV_EN
      OP_W'(ALU_MUL):  w_is_long = 1'b1;
      OP_W'(ALU_DIVU): begin
        if (b == ZERO_W) begin
          w_y    = '1;
          w_y_hi = a;
          w_err  = 1'b1;
        end else begin
          w_is_long = 1'b1;
        end
      end
`endif
      OP_W'(ALU_OFF):  w_y = ZERO_W;
      default:         w_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic             w_done;
  logic [WIDTH-1:0] w_lo, w_hi;

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_acc && w_is_long),
    .a      (a),
    .b      (b),
    .is_div (op == OP_W'(ALU_DIVU)),
    .done   (w_done),
    .lo     (w_lo),
    .hi     (w_hi)
  );
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc) w_state_nxt = w_is_long ? ST_CALC : ST_DONE;
`ifdef SEQ_ALU_MULDIV_EN
      ST_CALC: if (w_done) w_state_nxt = ST_DONE;
`endif
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result registers: loaded on a single-cycle accept or at the end of CALC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y    <= ZERO_W;
      r_y_hi <= ZERO_W;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_acc && !w_is_long) begin
      r_y    <= w_y;
      r_y_hi <= w_y_hi;
      r_zero <= (w_y == ZERO_W);
      r_ovf  <= w_ovf;
      r_err  <= w_err;
    end
`ifdef SEQ_ALU_MULDIV_EN
    else if (r_state == ST_CALC && w_done) begin
      r_y    <= w_lo;
      r_y_hi <= w_hi;
      r_zero <= (w_lo == ZERO_W);
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end
`endif
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign y         = r_y;
  assign y_hi      = r_y_hi;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign err       = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32). Expectations follow the build's
// SEQ_ALU_MULDIV_EN setting.
module tb_seq_alu;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, y, y_hi;
  logic        zero, ovf, err;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] y;
    logic [31:0] yhi;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
    exp_t e;
    logic [63:0] p;
    logic [31:0] bp;
    e.y = 0; e.yhi = 0; e.ovf = 0; e.err = 0; e.lat = 1;
    case (o)
      4'd0: e.y = x & z;
      4'd1: e.y = x | z;
      4'd2: begin e.y = x + z; e.ovf = (x[31] == z[31]) && (e.y[31] != x[31]); end
      4'd3: begin bp = ~z + 32'd1; e.y = x - z; e.ovf = (x[31] == bp[31]) && (e.y[31] != x[31]); end
      4'd4: e.y = ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
      4'd5: e.y = (x < z) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_MULDIV_EN
      4'd6: begin p = {32'd0, x} * {32'd0, z}; e.y = p[31:0]; e.yhi = p[63:32]; e.lat = 33; end
      4'd7: begin
        if (z == 0) begin e.y = 32'hFFFFFFFF; e.yhi = x; e.err = 1; end
        else begin e.y = x / z; e.yhi = x % z; e.lat = 33; end
      end
`endif
      4'd8: e.y = 0;
      default: e.err = 1;
    endcase
    e.zero = (e.y == 0);
    return e;
  endfunction

  // Drive one op, wait for its result and compare against the scoreboard.
  // With hold set, out_ready stays low and the result is left pending.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z, input bit hold);
    exp_t e;
    int   lat;
    int   guard;
    sb.push_back(model(o, x, z));
    @(negedge clk);
    in_valid = 1; op = o; a = x; b = z; out_ready = !hold;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      chk("handshake_timeout", 0, 1);
      in_valid = 0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("out_valid", out_valid, 1);
    chk("y", y, e.y);
    chk("y_hi", y_hi, e.yhi);
    chk("zero", zero, e.zero);
    chk("ovf", ovf, e.ovf);
    chk("err", err, e.err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    clk = 0; rst_n = 0; in_valid = 0; op = 0; a = 0; b = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y", y, 0);
    chk("rst_y_hi", y_hi, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    rst_n = 1;

    run_op(4'd2, 32'h7FFFFFFF, 32'h1, 0);
    chk("add_y_const", y, 32'h80000000);
    @(negedge clk);
    chk("one_cycle_valid", out_valid, 0);
    chk("ready_after", in_ready, 1);

    run_op(4'd3, 32'd8, 32'd8, 0);
    run_op(4'd3, 32'h80000000, 32'd1, 0);
    run_op(4'd4, 32'hFFFFFFFD, 32'hFFFFFFFB, 0);
    run_op(4'd4, 32'hFFFFFFFB, 32'h5, 0);
    run_op(4'd5, 32'd1, 32'hFFFFFFFF, 0);
    run_op(4'd0, 32'hF0F0A5A5, 32'h0FF0FFFF, 0);
    run_op(4'd1, 32'hF0000000, 32'h0000000F, 0);
    run_op(4'd8, 32'h12345678, 32'h9ABCDEF0, 0);
    run_op(4'd6, 32'hFFFFFFFF, 32'd2, 0);
    run_op(4'd7, 32'd41, 32'd8, 0);
    run_op(4'd7, 32'hDEADBEEF, 32'd0, 0);
    run_op(4'hF, 32'h1, 32'h2, 0);

    // Stall in DONE: result stable, new request ignored
    run_op(4'd2, 32'd5, 32'd6, 1);
    in_valid = 1; op = 4'd3; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_y", y, 32'd11);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("stall_release_valid", out_valid, 0);
    chk("stall_release_ready", in_ready, 1);
    @(negedge clk);
    chk("stall_no_extra", out_valid, 0);

    // Reset while an op is in flight aborts it
    in_valid = 1; a = 32'h12345; b = 32'h777;
`ifdef SEQ_ALU_MULDIV_EN
    op = 4'd6; out_ready = 1;
`else
    op = 4'd2; out_ready = 0;
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_y", y, 0);
    chk("abort_y_hi", y_hi, 0);
    chk("abort_flags", {zero, ovf, err}, 0);
    rst_n = 1; out_ready = 1;
    repeat (40) @(negedge clk);
    chk("abort_no_result", out_valid, 0);

    // Random mix, including zero divisors and illegal codes
    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 0) ra = ra >> $urandom_range(0, 31);
      run_op(ro, ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
